ysyx_22050019_wbu: RTL

Write-back stage of the NPC pipeline. It sits directly upstream of the general-purpose register file.
- Accepts one retired instruction per cycle from the memory stage over a valid/ready handshake and holds it in a single-entry WB register.
- Selects and extends the result, then drives the register file's write port (wen/waddr/wdata) and the commit PC used for difftest.
- Counts retired instructions and halts the core after an ebreak commits.

---
 rtl/ysyx_22050019_wbu_pkg.sv | 13 +
 rtl/ysyx_22050019_ld_ext.sv | 27 ++
 rtl/ysyx_22050019_wbu.sv | 97 +++++++++
 3 files changed

// File: rtl/ysyx_22050019_wbu_pkg.sv
// ysyx_22050019_wbu_pkg: shared constants for the write-back stage and load extender
package ysyx_22050019_wbu_pkg;
    localparam int WBU_DATA_WIDTH = 64;
    localparam int WBU_ADDR_WIDTH = 5;
    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_CSR  = 2'd2;
    localparam logic [1:0] WB_SEL_PC4  = 2'd3;
    localparam logic [1:0] LD_SIZE_B = 2'd0;
    localparam logic [1:0] LD_SIZE_H = 2'd1;
    localparam logic [1:0] LD_SIZE_W = 2'd2;
    localparam logic [1:0] LD_SIZE_D = 2'd3;
endpackage

// File: rtl/ysyx_22050019_ld_ext.sv
// ysyx_22050019_ld_ext: picks the addressed lane of a doubleword and sign/zero-extends it
module ysyx_22050019_ld_ext
    import ysyx_22050019_wbu_pkg::*;
#(
    parameter int DATA_WIDTH = WBU_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [2:0]            off,
    input  logic [1:0]            size,
    input  logic                  ld_unsigned,
    output logic [DATA_WIDTH-1:0] ext
);
    logic [5:0]            sh;
    logic [DATA_WIDTH-1:0] lane;
    logic                  sx;
    // Low offset bits below the access size are dropped, so misaligned offsets round down to the lane
    always_comb begin
        sh   = size == LD_SIZE_H ? {off[2:1], 4'b0} :
               size == LD_SIZE_W ? {off[2], 5'b0} :
               size == LD_SIZE_B ? {off, 3'b0} : 6'd0;
        lane = rdata >> sh;
        sx   = ~ld_unsigned;
        ext  = size == LD_SIZE_B ? {{(DATA_WIDTH-8){sx & lane[7]}}, lane[7:0]} :
               size == LD_SIZE_H ? {{(DATA_WIDTH-16){sx & lane[15]}}, lane[15:0]} :
               size == LD_SIZE_W ? {{(DATA_WIDTH-32){sx & lane[31]}}, lane[31:0]} : lane;
    end
endmodule

// File: rtl/ysyx_22050019_wbu.sv
// ysyx_22050019_wbu: write-back stage holding one retired instruction and driving the register-file write port
module ysyx_22050019_wbu
    import ysyx_22050019_wbu_pkg::*;
#(
    parameter int ADDR_WIDTH = WBU_ADDR_WIDTH,
    parameter int DATA_WIDTH = WBU_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_rd_wen,
    input  logic [1:0]            in_wb_sel,
    input  logic [DATA_WIDTH-1:0] in_alu_res,
    input  logic [DATA_WIDTH-1:0] in_csr_rdata,
    input  logic [DATA_WIDTH-1:0] in_ld_rdata,
    input  logic [2:0]            in_ld_off,
    input  logic [1:0]            in_ld_size,
    input  logic                  in_ld_unsigned,
    input  logic                  in_ebreak,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  commit_valid,
    output logic [DATA_WIDTH-1:0] commit_pc,
    output logic [63:0]           retire_cnt,
    output logic                  halted
);
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                  rd_wen_q, rd_wen_d;
    logic                  ebreak_q, ebreak_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  halted_q, halted_d;
    logic [63:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] ld_val;
    logic                  xfer;

    ysyx_22050019_ld_ext #(.DATA_WIDTH(DATA_WIDTH)) u_ld_ext (
        .rdata       (in_ld_rdata),
        .off         (in_ld_off),
        .size        (in_ld_size),
        .ld_unsigned (in_ld_unsigned),
        .ext         (ld_val)
    );

    // Result is finalised before the register; halt latches once a held ebreak is seen
    always_comb begin
        xfer     = in_valid && !halted_q;
        valid_d  = xfer;
        pc_d     = xfer ? in_pc : pc_q;
        rd_d     = xfer ? in_rd : rd_q;
        rd_wen_d = xfer ? in_rd_wen : rd_wen_q;
        ebreak_d = xfer ? in_ebreak : ebreak_q;
        res_d    = !xfer ? res_q :
                   in_wb_sel == WB_SEL_ALU  ? in_alu_res :
                   in_wb_sel == WB_SEL_LOAD ? ld_val :
                   in_wb_sel == WB_SEL_CSR  ? in_csr_rdata : in_pc + DATA_WIDTH'(4);
        halted_d = halted_q || (valid_q && ebreak_q);
        cnt_d    = cnt_q + {63'd0, valid_q};
    end

    // WB register, retire counter and halt flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            rd_q     <= '0;
            rd_wen_q <= 1'b0;
            ebreak_q <= 1'b0;
            res_q    <= '0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            rd_q     <= rd_d;
            rd_wen_q <= rd_wen_d;
            ebreak_q <= ebreak_d;
            res_q    <= res_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready     = !halted_q;
    assign rf_wen       = valid_q && rd_wen_q && (rd_q != '0);
    assign rf_waddr     = rd_q;
    assign rf_wdata     = res_q;
    assign commit_valid = valid_q;
    assign commit_pc    = pc_q;
    assign retire_cnt   = cnt_q;
    assign halted       = halted_q;
endmodule
